calc_sequencer: RTL

//  Control FSM for the lab4 serial calculator. Parses a 4-character ASCII expression from the UART receiver.

---
 rtl/calc_seq_pkg.sv | 52 +++++
 rtl/calc_tx_sender.sv | 61 ++++++
 rtl/calc_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/calc_seq_pkg.sv
// Shared definitions for the lab4 serial calculator sequencer: ASCII
// constants, FSM state encodings, the operand record and the result
// string type, plus small byte-classification helpers.
package calc_seq_pkg;

  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] NINE  = 8'h39;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  // Longest reply: sign, tens, units, CR, LF.
  localparam int MAX_LEN = 5;
  localparam int IDX_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    GET_D1,
    GET_S2,
    GET_D2,
    CALC,
    TX,
    ERR_TX
  } state_t;

  typedef enum logic [1:0] {
    SND_IDLE,
    SND_WAIT,
    SND_WRITE,
    SND_GUARD
  } snd_state_t;

  // One signed operand as received: sign flag plus decimal digit.
  typedef struct packed {
    logic       neg;
    logic [3:0] mag;
  } term_t;

  // Reply string, element 0 is sent first.
  typedef logic [MAX_LEN-1:0][7:0] str_t;

  function automatic logic is_sign(input logic [7:0] b);
    return (b == PLUS) || (b == MINUS);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ZERO) && (b <= NINE);
  endfunction

endpackage

// File: rtl/calc_tx_sender.sv
// Byte sender for the UART transmitter. Accepts one byte per load strobe,
// waits for the transmitter to be idle, issues a one-cycle tx_wr, then
// ignores tx_busy for one guard cycle (the transmitter raises busy a cycle
// late) before pulsing done so the next byte can be loaded.
import calc_seq_pkg::*;

module calc_tx_sender (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  output logic       done,
  output logic       idle
);

  snd_state_t st_q;

  assign idle = (st_q == SND_IDLE);

  // Handshake sequencing; tx_data is only updated on load so it stays
  // stable through the write strobe.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= SND_IDLE;
      tx_data <= 8'h00;
      tx_wr   <= 1'b0;
      done    <= 1'b0;
    end else begin
      tx_wr <= 1'b0;
      done  <= 1'b0;
      case (st_q)
        SND_IDLE: begin
          if (load) begin
            tx_data <= din;
            st_q    <= SND_WAIT;
          end
        end
        SND_WAIT: begin
          if (!tx_busy) begin
            tx_wr <= 1'b1;
            st_q  <= SND_WRITE;
          end
        end
        SND_WRITE: begin
          st_q <= SND_GUARD;
        end
        SND_GUARD: begin
          done <= 1'b1;
          st_q <= SND_IDLE;
        end
        default: st_q <= SND_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Control FSM for the lab4 serial calculator. Parses "s1 d1 s2 d2" from the
// UART receiver, computes the signed sum and sends it back as ASCII
// (sign, optional tens, units, CR, LF); malformed or stalled input replies
// "?" CR LF and raises the sticky err flag.
// Optional feature macro: CALC_SEQ_ECHO_EN -- echoes each accepted byte
// through a one-byte holding register while not transmitting a reply.
import calc_seq_pkg::*;

module calc_sequencer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  output logic       rx_drop,
  output logic       err,
  output logic       busy
);

  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t            state_q;
  term_t             t1_q, t2_q;
  logic [TO_W-1:0]   to_cnt;
  logic [IDX_W-1:0]  idx_q, len_q;
  logic              need_load;
  logic              snd_load;
  logic [7:0]        snd_byte;
  logic              snd_done, snd_idle;
  str_t              buf_q;

`ifdef CALC_SEQ_ECHO_EN
  logic [7:0]        echo_q;
  logic              echo_pend;
`endif

  logic              in_get, class_ok, accept, expire, go_err;
  logic signed [5:0] v1, v2, sum;
  logic [4:0]        mag;
  logic              tens;
  logic [3:0]        units;
  str_t              res_str;
  logic [IDX_W-1:0]  res_len;

  assign in_get  = (state_q inside {GET_D1, GET_S2, GET_D2});
  assign rx_drop = rx_valid && (state_q inside {CALC, TX, ERR_TX});
  assign expire  = (TIMEOUT_CYC != 0) && in_get && (to_cnt == TO_LAST);
  assign accept  = rx_valid && class_ok;
  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign go_err  = in_get && (rx_valid ? !class_ok : expire);

  // Which byte class the current state is waiting for.
  // NOTE: every combinational output gets a default first so no path
  // through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    class_ok = 1'b0;
    case (state_q)
      IDLE, GET_S2:   class_ok = is_sign(rx_data);
      GET_D1, GET_D2: class_ok = is_digit(rx_data);
      default:        class_ok = 1'b0;
    endcase
  end

  // Signed sum of the latched operands, rendered as the reply string.
  always_comb begin
    v1 = {2'b00, t1_q.mag};
    if (t1_q.neg) v1 = -v1;
    v2 = {2'b00, t2_q.mag};
    if (t2_q.neg) v2 = -v2;
    sum   = v1 + v2;
    mag   = sum[5] ? 5'(-sum) : 5'(sum);
    tens  = (mag >= 5'd10);
    units = tens ? 4'(mag - 5'd10) : mag[3:0];
    res_str    = '0;
    res_str[0] = sum[5] ? MINUS : PLUS;
    if (tens) begin
      res_str[1] = ZERO | 8'd1;
      res_str[2] = ZERO | {4'h0, units};
      res_str[3] = CR;
      res_str[4] = LF;
      res_len    = IDX_W'(5);
    end else begin
      res_str[1] = ZERO | {4'h0, units};
      res_str[2] = CR;
      res_str[3] = LF;
      res_len    = IDX_W'(4);
    end
  end

  // Reply buffer, loaded from the result in CALC or with "?" on error.
  // NOTE: this buffer has no reset on purpose: it is always written before
  // TX/ERR_TX reads it, so resetting it would add logic for no behaviour.
  always_ff @(posedge clk) begin
    if (state_q == CALC) begin
      buf_q <= res_str;
    end else if (go_err) begin
      buf_q    <= '0;
      buf_q[0] <= QMARK;
      buf_q[1] <= CR;
      buf_q[2] <= LF;
    end
  end

  // Main sequencer: parse, calculate, then feed the sender one byte per done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      err       <= 1'b0;
      t1_q      <= '0;
      t2_q      <= '0;
      to_cnt    <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      need_load <= 1'b0;
      snd_load  <= 1'b0;
      snd_byte  <= 8'h00;
`ifdef CALC_SEQ_ECHO_EN
      echo_q    <= 8'h00;
      echo_pend <= 1'b0;
`endif
    end else begin
      snd_load <= 1'b0;
`ifdef CALC_SEQ_ECHO_EN
      if (echo_pend && snd_idle && !snd_load &&
          (state_q inside {IDLE, GET_D1, GET_S2, GET_D2})) begin
        snd_load  <= 1'b1;
        snd_byte  <= echo_q;
        echo_pend <= 1'b0;
      end
      // Only the most recent accepted byte is kept for echo.
      if (accept) begin
        echo_q    <= rx_data;
        echo_pend <= 1'b1;
      end
`endif
      if (go_err) begin
        state_q   <= ERR_TX;
        err       <= 1'b1;
        len_q     <= IDX_W'(3);
        idx_q     <= '0;
        need_load <= 1'b1;
        to_cnt    <= '0;
`ifdef CALC_SEQ_ECHO_EN
        echo_pend <= 1'b0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (accept) begin
              t1_q.neg <= (rx_data == MINUS);
              err      <= 1'b0;
              busy     <= 1'b1;
              to_cnt   <= '0;
              state_q  <= GET_D1;
            end
          end
          GET_D1: begin
            if (accept) begin
              t1_q.mag <= rx_data[3:0];
              to_cnt   <= '0;
              state_q  <= GET_S2;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          GET_S2: begin
            if (accept) begin
              t2_q.neg <= (rx_data == MINUS);
              to_cnt   <= '0;
              state_q  <= GET_D2;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          GET_D2: begin
            if (accept) begin
              t2_q.mag <= rx_data[3:0];
              to_cnt   <= '0;
              state_q  <= CALC;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          CALC: begin
            len_q     <= res_len;
            idx_q     <= '0;
            need_load <= 1'b1;
            state_q   <= TX;
`ifdef CALC_SEQ_ECHO_EN
            echo_pend <= 1'b0;
`endif
          end
          TX, ERR_TX: begin
            // A done seen while a load is still owed belongs to an echo.
            if (need_load) begin
              if (snd_idle && !snd_load) begin
                snd_load  <= 1'b1;
                snd_byte  <= buf_q[idx_q];
                need_load <= 1'b0;
              end
            end else if (snd_done) begin
              if (idx_q == IDX_W'(len_q - IDX_W'(1))) begin
                state_q <= IDLE;
                busy    <= 1'b0;
              end else begin
                idx_q     <= idx_q + IDX_W'(1);
                need_load <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  calc_tx_sender u_sender (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (snd_load),
    .din     (snd_byte),
    .tx_busy (tx_busy),
    .tx_data (tx_data),
    .tx_wr   (tx_wr),
    .done    (snd_done),
    .idle    (snd_idle)
  );

endmodule
